mac_dot_sequencer: RTL and testbench
====================================

// Module: mac_dot_sequencer
// PURPOSE
//   Upstream operand feeder for mac_unit. Accepts a stream of 4-bit operand pairs grouped into vectors
//   (last flag marks end), buffers them in a small FIFO, clears the MAC, then issues one pair per cycle.
//   After the drain latency it captures the MAC result as one dot-product and hands it downstream
//   over a valid/ready handshake.
// PARAMETERS
//   DEPTH        4   input FIFO entries (power of 2, >=2)
//   MAC_LATENCY  1   cycles from last operand issue until mac_result holds the final sum (>=1)
//   CNT_W        8   width of per-vector element counter
// PORTS
//   clock       in   1      single clock, rising edge
//   reset_n     in   1      asynchronous, active-low reset
//   in_valid    in   1      upstream pair valid
//   in_ready    out  1      FIFO can accept (= FIFO not full)
//   in_a        in   4      operand a
//   in_b        in   4      operand b
//   in_last     in   1      pair is last element of its vector
//   mac_a       out  4      to mac_unit.operand_a (registered)
//   mac_b       out  4      to mac_unit.operand_b (registered)
//   mac_clear   out  1      to mac_unit.reset, active-high accumulator clear (registered)
//   mac_result  in   8      from mac_unit.result
//   dot_valid   out  1      dot_result valid
//   dot_ready   in   1      downstream accepts result
//   dot_result  out  8      captured dot-product, modulo 256
//   elem_count  out  CNT_W  pairs in captured vector, wraps modulo 2^CNT_W
//   busy        out  1      state != IDLE
// BEHAVIOUR
//   - One clock; reset is asynchronous and active-low.
//   - Reset: FIFO empty, state IDLE; mac_a=mac_b=0, mac_clear=0, dot_valid=0, dot_result=0,
//     elem_count=0, busy=0. Reset mid-vector discards FIFO contents and partial vector; no dot_valid.
//   - Push when in_valid && in_ready. in_ready depends only on FIFO fullness, not same-cycle pop.
//     Simultaneous push+pop with FIFO non-full: both occur, occupancy unchanged.
//   - MAC has no enable: every cycle not issuing a pair, mac_a=mac_b=0 (adds 0).
//   - FSM:
//     IDLE : mac_clear=0. FIFO non-empty -> CLEAR.
//     CLEAR: mac_clear=1 for exactly one cycle, operands 0; internal count=0 -> RUN.
//     RUN  : FIFO non-empty -> pop, drive mac_a/mac_b from head, count+1; popped last -> DRAIN
//            (drain counter = MAC_LATENCY). FIFO empty -> bubble (zeros), stay in RUN.
//     DRAIN: operands 0, decrement counter; on reaching 0 register dot_result<=mac_result,
//            elem_count<=count, dot_valid<=1 -> DONE.
//     DONE : hold dot_result/dot_valid stable until dot_ready; on dot_valid&&dot_ready clear
//            dot_valid -> IDLE. FIFO keeps accepting pushes while in DRAIN/DONE.
//   - Issue rate: one pair per cycle when FIFO non-empty; first pair appears the cycle after
//     mac_clear. Latency from push of first pair into empty FIFO (IDLE) to its issue: 3 cycles.
//   - Arithmetic done by mac_unit; result wraps modulo 256, no saturation, no overflow flag.
//   - A vector of one pair (in_last on first pair) is legal. Pairs beyond 2^CNT_W wrap elem_count.
//   - dot_ready high while dot_valid low has no effect.
// TESTING
//   1. Push (2,3),(4,5),(1,7,last) back-to-back, dot_ready=1 -> one mac_clear pulse, three issue
//      cycles, dot_result=33, elem_count=3, dot_valid for one cycle.
//   2. Four pairs (15,15), last on 4th -> dot_result=132 (900 mod 256), elem_count=4.
//   3. Same as 1 with 2-cycle gap between pairs -> mac_a/mac_b=0 in gaps, dot_result=33 unchanged.
//   4. dot_ready=0, push 4 more pairs after vector 1 -> FIFO fills, in_ready=0, dot_result holds 33;
//      raise dot_ready -> next vector cleared and processed in order.
//   5. Single-pair vector (6,9,last) -> dot_result=54, elem_count=1.
//   6. Assert reset_n=0 mid-RUN of 3-pair vector -> all outputs to reset values immediately, no
//      dot_valid; after release, new vector (1,1,last) -> dot_result=1.

Source files
------------

// File: rtl/mac_dot_sequencer.sv
// mac_dot_sequencer: operand feeder for mac_unit.
// Buffers 4-bit operand pairs in a small FIFO, clears the MAC at the start of
// each vector, issues one pair per cycle, waits out the MAC latency, then
// captures the dot-product and offers it downstream on a valid/ready handshake.
module mac_dot_sequencer #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned MAC_LATENCY = 1,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  input  logic             in_last,
  output logic [3:0]       mac_a,
  output logic [3:0]       mac_b,
  output logic             mac_clear,
  input  logic [7:0]       mac_result,
  output logic             dot_valid,
  input  logic             dot_ready,
  output logic [7:0]       dot_result,
  output logic [CNT_W-1:0] elem_count,
  output logic             busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned DW = $clog2(MAC_LATENCY + 1);
  localparam logic [AW:0]      PTR_ONE    = 1;
  localparam logic [DW-1:0]    DRAIN_INIT = DW'(MAC_LATENCY);
  localparam logic [DW-1:0]    DRAIN_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_ONE    = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_d;

  // FIFO storage: {last, a, b}
  logic [8:0]  mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        fifo_empty, fifo_full;
  logic        push, pop;
  logic [3:0]  head_a, head_b;
  logic        head_last;

  // Datapath next values
  logic [3:0]       mac_a_d, mac_b_d;
  logic             mac_clear_d;
  logic [CNT_W-1:0] count, count_d;
  logic [DW-1:0]    drain, drain_d;
  logic             dot_valid_d;
  logic             capture;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready   = !fifo_full;
  assign push       = in_valid && !fifo_full;
  assign {head_last, head_a, head_b} = mem[rd_ptr[AW-1:0]];
  assign busy       = (state != S_IDLE);

  // FIFO storage write; contents need no reset since pointers gate visibility
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {in_last, in_a, in_b};
    end
  end

  // FIFO pointers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Next-state and registered-output decode.
  // Outputs are computed for the state being entered so that mac_clear is
  // high exactly while in CLEAR and operands appear the cycle after it.
  // DRAIN holds MAC_LATENCY+1 cycles: the counter runs down MAC_LATENCY edges
  // while the MAC absorbs the last pair, and capture happens on the edge after
  // mac_result has settled.
  always_comb begin
    state_d     = state;
    pop         = 1'b0;
    mac_a_d     = '0;
    mac_b_d     = '0;
    mac_clear_d = 1'b0;
    count_d     = count;
    drain_d     = drain;
    dot_valid_d = dot_valid;
    capture     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_d     = S_CLEAR;
          mac_clear_d = 1'b1;
        end
      end
      S_CLEAR: begin
        count_d = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          mac_a_d = head_a;
          mac_b_d = head_b;
          count_d = count + CNT_ONE;
          if (head_last) begin
            state_d = S_DRAIN;
            drain_d = DRAIN_INIT;
          end
        end
      end
      S_DRAIN: begin
        if (drain == '0) begin
          capture     = 1'b1;
          dot_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          drain_d = drain - DRAIN_ONE;
        end
      end
      S_DONE: begin
        if (dot_ready) begin
          dot_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, MAC interface and control registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      mac_a     <= '0;
      mac_b     <= '0;
      mac_clear <= 1'b0;
      count     <= '0;
      drain     <= '0;
      dot_valid <= 1'b0;
    end else begin
      state     <= state_d;
      mac_a     <= mac_a_d;
      mac_b     <= mac_b_d;
      mac_clear <= mac_clear_d;
      count     <= count_d;
      drain     <= drain_d;
      dot_valid <= dot_valid_d;
    end
  end

  // Result capture, held stable through DONE
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dot_result <= '0;
      elem_count <= '0;
    end else if (capture) begin
      dot_result <= mac_result;
      elem_count <= count;
    end
  end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Testbench for mac_dot_sequencer with a behavioural mac_unit (1-cycle latency).
module tb_mac_dot_sequencer;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a, in_b;
  logic       in_last;
  logic [3:0] mac_a, mac_b;
  logic       mac_clear;
  logic [7:0] mac_result;
  logic       dot_valid;
  logic       dot_ready;
  logic [7:0] dot_result;
  logic [7:0] elem_count;
  logic       busy;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  int unsigned clear_seen = 0;
  int unsigned issue_seen = 0;
  int unsigned dv_seen    = 0;

  mac_dot_sequencer #(
    .DEPTH(4),
    .MAC_LATENCY(1),
    .CNT_W(8)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .in_last(in_last),
    .mac_a(mac_a),
    .mac_b(mac_b),
    .mac_clear(mac_clear),
    .mac_result(mac_result),
    .dot_valid(dot_valid),
    .dot_ready(dot_ready),
    .dot_result(dot_result),
    .elem_count(elem_count),
    .busy(busy)
  );

  always #5 clock = ~clock;

  // Behavioural mac_unit: clear or accumulate a*b each cycle, modulo 256
  logic [7:0] acc;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n)       acc <= 8'd0;
    else if (mac_clear) acc <= 8'd0;
    else                acc <= acc + ({4'd0, mac_a} * {4'd0, mac_b});
  end
  assign mac_result = acc;

  // Event monitor, sampled away from the active edge
  always @(negedge clock) begin
    if (reset_n) begin
      if (mac_clear) clear_seen++;
      if (mac_a != 4'd0 || mac_b != 4'd0) issue_seen++;
      if (dot_valid) dv_seen++;
    end
  end

  typedef struct {
    int unsigned n;
    logic [15:0] a;
    logic [15:0] b;
    int unsigned gap;
    logic [7:0]  exp_res;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the pair was accepted
  task automatic push(input logic [3:0] a, input logic [3:0] b, input logic last);
    int unsigned t;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    t = 0;
    while (!in_ready && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (!in_ready) check("push_timeout_in_ready", 32'(in_ready), 32'd1);
    @(negedge clock);
    in_valid = 1'b0;
    in_a     = 4'd0;
    in_b     = 4'd0;
    in_last  = 1'b0;
  endtask

  task automatic wait_dot(input string tag);
    int unsigned t;
    t = 0;
    while (!dot_valid && t < 200) begin
      @(negedge clock);
      t++;
    end
    check({tag, "_dot_valid"}, 32'(dot_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c0, i0, d0;
    logic last;

    vecs[0] = '{3, 16'h0142, 16'h0753, 0, 8'd33,  8'd3};
    vecs[1] = '{4, 16'hFFFF, 16'hFFFF, 0, 8'd132, 8'd4};
    vecs[2] = '{3, 16'h0142, 16'h0753, 2, 8'd33,  8'd3};
    vecs[3] = '{1, 16'h0006, 16'h0009, 0, 8'd54,  8'd1};

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_a      = 4'd0;
    in_b      = 4'd0;
    in_last   = 1'b0;
    dot_ready = 1'b1;
    repeat (3) @(negedge clock);

    check("rst_busy",       32'(busy),       32'd0);
    check("rst_dot_valid",  32'(dot_valid),  32'd0);
    check("rst_dot_result", 32'(dot_result), 32'd0);
    check("rst_elem_count", 32'(elem_count), 32'd0);
    check("rst_mac_clear",  32'(mac_clear),  32'd0);
    check("rst_mac_a",      32'(mac_a),      32'd0);
    check("rst_mac_b",      32'(mac_b),      32'd0);
    check("rst_in_ready",   32'(in_ready),   32'd1);

    reset_n = 1'b1;
    @(negedge clock);

    // Table-driven vectors
    for (int v = 0; v < 4; v++) begin
      c0 = clear_seen;
      i0 = issue_seen;
      for (int i = 0; i < int'(vecs[v].n); i++) begin
        last = ((i + 1) == int'(vecs[v].n));
        push(vecs[v].a[i*4 +: 4], vecs[v].b[i*4 +: 4], last);
        repeat (vecs[v].gap) @(negedge clock);
      end
      wait_dot($sformatf("vec%0d", v));
      check($sformatf("vec%0d_dot_result", v), 32'(dot_result), 32'(vecs[v].exp_res));
      check($sformatf("vec%0d_elem_count", v), 32'(elem_count), 32'(vecs[v].exp_cnt));
      check($sformatf("vec%0d_clear_pulses", v), clear_seen - c0, 32'd1);
      check($sformatf("vec%0d_issue_cycles", v), issue_seen - i0, vecs[v].n);
      @(negedge clock);
      check($sformatf("vec%0d_dot_valid_one_cycle", v), 32'(dot_valid), 32'd0);
      repeat (2) @(negedge clock);
    end

    // Backpressure: result held while FIFO fills behind it
    dot_ready = 1'b0;
    push(4'd2, 4'd3, 1'b0);
    push(4'd4, 4'd5, 1'b0);
    push(4'd1, 4'd7, 1'b1);
    push(4'd1, 4'd2, 1'b0);
    push(4'd3, 4'd4, 1'b0);
    push(4'd5, 4'd6, 1'b0);
    push(4'd7, 4'd8, 1'b1);
    repeat (6) @(negedge clock);
    check("bp_in_ready_full", 32'(in_ready),   32'd0);
    check("bp_dot_valid",     32'(dot_valid),  32'd1);
    check("bp_dot_result",    32'(dot_result), 32'd33);
    check("bp_elem_count",    32'(elem_count), 32'd3);
    check("bp_busy",          32'(busy),       32'd1);
    dot_ready = 1'b1;
    @(negedge clock);
    check("bp_handshake_clears", 32'(dot_valid), 32'd0);
    wait_dot("bp_second");
    check("bp_second_dot_result", 32'(dot_result), 32'd100);
    check("bp_second_elem_count", 32'(elem_count), 32'd4);
    check("bp_in_ready_drained",  32'(in_ready),   32'd1);
    repeat (3) @(negedge clock);

    // Reset in the middle of a vector
    push(4'd2, 4'd2, 1'b0);
    push(4'd3, 4'd3, 1'b0);
    repeat (2) @(negedge clock);
    check("mid_busy_before_reset", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy",       32'(busy),       32'd0);
    check("mid_rst_mac_a",      32'(mac_a),      32'd0);
    check("mid_rst_mac_b",      32'(mac_b),      32'd0);
    check("mid_rst_mac_clear",  32'(mac_clear),  32'd0);
    check("mid_rst_dot_valid",  32'(dot_valid),  32'd0);
    check("mid_rst_dot_result", 32'(dot_result), 32'd0);
    check("mid_rst_elem_count", 32'(elem_count), 32'd0);
    check("mid_rst_in_ready",   32'(in_ready),   32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    d0 = dv_seen;
    repeat (10) @(negedge clock);
    check("mid_no_dot_valid_after", dv_seen - d0, 32'd0);
    check("mid_idle_after",         32'(busy),   32'd0);
    push(4'd1, 4'd1, 1'b1);
    wait_dot("post_rst");
    check("post_rst_dot_result", 32'(dot_result), 32'd1);
    check("post_rst_elem_count", 32'(elem_count), 32'd1);
    repeat (3) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
